// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: widths, opcode map and response payload.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned SHAMT_W = 6;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_SLL = 4'b0101,
    OP_SRL = 4'b0110,
    OP_SRA = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_BNE = 4'b1001,
    OP_BLT = 4'b1010,
    OP_BGE = 4'b1011
  } alu_op_e;

  // Opcodes at or above this value are not defined.
  localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 4'b1100;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  typedef struct packed {
    logic              id;
    logic [DATA_W-1:0] result;
    logic              branch;
    logic              err;
  } alu_rsp_t;

  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return op >= OP_ILLEGAL_MIN;
  endfunction

  function automatic logic op_is_cmp(input logic [OP_W-1:0] op);
    return (op >= OP_BEQ) && (op < OP_ILLEGAL_MIN);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic/logic result plus branch-compare outcome.
module alu
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  output logic [DATA_W-1:0] result_o,
  output logic              branch_o
);

  logic [SHAMT_W-1:0] shamt;
  logic               shamt_big;
  logic [4:0]         sh;

  assign shamt     = opb_i[SHAMT_W-1:0];
  assign shamt_big = shamt[SHAMT_W-1];
  assign sh        = shamt[4:0];

  // Shift amounts of 32..63 flush the operand out entirely.
  always_comb begin
    result_o = '0;
    branch_o = 1'b0;
    case (op_i)
      OP_ADD: result_o = opa_i + opb_i;
      OP_SUB: result_o = opa_i - opb_i;
      OP_AND: result_o = opa_i & opb_i;
      OP_OR:  result_o = opa_i | opb_i;
      OP_XOR: result_o = opa_i ^ opb_i;
      OP_SLL: result_o = shamt_big ? '0 : (opa_i << sh);
      OP_SRL: result_o = shamt_big ? '0 : (opa_i >> sh);
      OP_SRA: result_o = shamt_big ? {DATA_W{opa_i[DATA_W-1]}}
                                   : DATA_W'($signed(opa_i) >>> sh);
      OP_BEQ: branch_o = (opa_i == opb_i);
      OP_BNE: branch_o = (opa_i != opb_i);
      OP_BLT: branch_o = ($signed(opa_i) <  $signed(opb_i));
      OP_BGE: branch_o = ($signed(opa_i) >= $signed(opb_i));
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_rr_pick.sv
// Two-input round-robin grant with a pointer that favours the requester not served last.
module alu_rr_pick (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       can_issue_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = 2'b00;
    if (can_issue_i) begin
      case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end
  end

  // After any grant the other requester gets priority.
  always_comb begin
    ptr_d = ptr_q;
    if (|grant_o) ptr_d = ~grant_o[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the execute (0) and branch (1) requesters behind a one-entry response register.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_opa,
  input  logic [DATA_W-1:0] req0_opb,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_opa,
  input  logic [DATA_W-1:0] req1_opb,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_branch,
  output logic              rsp_err
);

  import alu_pkg::*;

  rsp_state_e        state_q;
  alu_rsp_t          rsp_q, rsp_d;
  logic              can_issue;
  logic [1:0]        grant;
  logic              any_grant;
  logic              sel;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] opa, opb;
  logic [DATA_W-1:0] alu_result;
  logic              alu_branch;

  assign can_issue = (state_q == RSP_EMPTY) || rsp_ready;
  assign any_grant = |grant;
  assign sel       = grant[1];

  alu_rr_pick u_pick (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     ({req1_valid, req0_valid}),
    .can_issue_i (can_issue),
    .grant_o     (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Only the granted requester's operands reach the ALU.
  assign op  = sel ? req1_op  : req0_op;
  assign opa = sel ? req1_opa : req0_opa;
  assign opb = sel ? req1_opb : req0_opb;

  alu u_alu (
    .op_i     (op),
    .opa_i    (opa),
    .opb_i    (opb),
    .result_o (alu_result),
    .branch_o (alu_branch)
  );

  // Each response carries only the field its opcode class owns; everything else is zero.
  always_comb begin
    rsp_d    = '0;
    rsp_d.id = sel;
    if (op_is_illegal(op))  rsp_d.err    = 1'b1;
    else if (op_is_cmp(op)) rsp_d.branch = alu_branch;
    else                    rsp_d.result = alu_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RSP_EMPTY;
      rsp_q   <= '0;
    end else begin
      case (state_q)
        RSP_EMPTY: begin
          if (any_grant) begin
            state_q <= RSP_FULL;
            rsp_q   <= rsp_d;
          end
        end
        RSP_FULL: begin
          if (any_grant)      rsp_q   <= rsp_d;
          else if (rsp_ready) state_q <= RSP_EMPTY;
        end
        default: state_q <= RSP_EMPTY;
      endcase
    end
  end

  assign rsp_valid  = (state_q == RSP_FULL);
  assign rsp_id     = rsp_q.id;
  assign rsp_result = rsp_q.result;
  assign rsp_branch = rsp_q.branch;
  assign rsp_err    = rsp_q.err;

endmodule
